// File: rtl/booth_pkg.sv
// Purpose : shared types, constants and helpers for the radix-4 Booth multiplier.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: state_t FSM encoding, Booth select codes, booth_iter(), booth_sel().
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Booth partial-product select codes
  localparam logic [2:0] ZERO = 3'd0;
  localparam logic [2:0] PM   = 3'd1;
  localparam logic [2:0] P2M  = 3'd2;
  localparam logic [2:0] NM   = 3'd3;
  localparam logic [2:0] N2M  = 3'd4;

  // Number of radix-4 steps needed to consume a (width+2)-bit extended multiplier
  function automatic int booth_iter(input int width);
    return (width + 2) / 2;
  endfunction

  // Maps the triplet {q[1], q[0], q_-1} onto a partial-product select
  function automatic logic [2:0] booth_sel(input logic [2:0] triplet);
    logic [2:0] sel;
    case (triplet)
      3'b001, 3'b010: sel = PM;
      3'b011:         sel = P2M;
      3'b100:         sel = N2M;
      3'b101, 3'b110: sel = NM;
      default:        sel = ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_radix4_encoder.sv
// Purpose : radix-4 Booth encoder; turns a triplet plus extended M into a signed addend.
// Latency : combinational.
// Backpressure: none.
// Ports   : i_triplet {q1,q0,q_1}; i_m_ext multiplicand extended to WIDTH+2 bits;
//           o_addend WIDTH+3-bit two's-complement addend (0, +-M or +-2M).
module booth_radix4_encoder
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       i_triplet,
  input  logic [WIDTH+1:0] i_m_ext,
  output logic [WIDTH+2:0] o_addend
);

  logic [WIDTH+2:0] w_m;
  logic [WIDTH+2:0] w_m2;

  // +M sign-extended by one more bit; +2M is a left shift, and the extra bit
  // keeps 2*(most negative) representable.
  assign w_m  = {i_m_ext[WIDTH+1], i_m_ext};
  assign w_m2 = {i_m_ext, 1'b0};

  always_comb begin
    o_addend = '0;
    case (booth_sel(i_triplet))
      PM:      o_addend = w_m;
      P2M:     o_addend = w_m2;
      NM:      o_addend = -w_m;
      N2M:     o_addend = -w_m2;
      default: o_addend = '0;
    endcase
  end

endmodule

// File: rtl/booth_multiply_radix4_fsmd.sv
// Purpose : iterative radix-4 Booth multiplier, signed or unsigned per operation.
// Latency : accept at cycle 0, data_valid_o in cycle ITER+1, ready_o again in ITER+2.
// Backpressure: start_i ignored unless ready_o (IDLE); no output stall, result pulses once.
// Ports   : clk_i, reset_i (sync, active-high), start_i/ready_o handshake, signed_i mode,
//           multiplicand_i/multiplier_i operands, data_valid_o pulse, product_o (2*WIDTH).
// Option  : define BOOTH_ZERO_BYPASS_EN to skip CALC when either operand is zero.
module booth_multiply_radix4_fsmd
  import booth_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ITER  = booth_iter(WIDTH)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic                 signed_i,
  input  logic [WIDTH-1:0]     multiplicand_i,
  input  logic [WIDTH-1:0]     multiplier_i,
  output logic                 ready_o,
  output logic                 data_valid_o,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int EW = WIDTH + 2;   // extended operand width
  localparam int SW = WIDTH + 3;   // adder width
  localparam int CW = $clog2(ITER);

  state_t             r_state;
  logic               r_signed;
  logic [WIDTH-1:0]   r_mcand;
  logic [EW-1:0]      r_acc;
  logic [EW-1:0]      r_q;
  logic               r_q_1;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_product;

  logic [EW-1:0]      w_mcand_ext;
  logic [EW-1:0]      w_mplier_ext;
  logic [2:0]         w_triplet;
  logic [SW-1:0]      w_addend;
  logic [SW-1:0]      w_sum;
  logic [EW-1:0]      w_acc_nxt;
  logic [EW-1:0]      w_q_nxt;
  logic [2*WIDTH-1:0] w_prod_nxt;
  logic               w_bypass;

  // Only the raw multiplicand and the mode are stored; the extension is
  // rebuilt each CALC cycle from them.
  assign w_mcand_ext  = r_signed ? {{2{r_mcand[WIDTH-1]}}, r_mcand} : {2'b00, r_mcand};
  assign w_mplier_ext = signed_i ? {{2{multiplier_i[WIDTH-1]}}, multiplier_i}
                                 : {2'b00, multiplier_i};
  assign w_triplet    = {r_q[1:0], r_q_1};

  booth_radix4_encoder #(
    .WIDTH (WIDTH)
  ) u_enc (
    .i_triplet (w_triplet),
    .i_m_ext   (w_mcand_ext),
    .o_addend  (w_addend)
  );

  assign w_sum = {r_acc[EW-1], r_acc} + w_addend;

  // Arithmetic shift right by 2 of the {sum, q, q_1} chain. The sum's two
  // low bits drop into the top of q; acc is re-sign-extended to EW bits.
  assign w_acc_nxt  = {w_sum[SW-1], w_sum[SW-1:2]};
  assign w_q_nxt    = {w_sum[1:0], r_q[EW-1:2]};
  // Low 2*WIDTH bits of {acc, q} after the final shift.
  assign w_prod_nxt = {w_acc_nxt[WIDTH-3:0], w_q_nxt};

`ifdef BOOTH_ZERO_BYPASS_EN
  assign w_bypass = (multiplicand_i == '0) || (multiplier_i == '0);
`else
  assign w_bypass = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= IDLE;
      r_signed  <= 1'b0;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_q       <= '0;
      r_q_1     <= 1'b0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_signed <= signed_i;
            r_mcand  <= multiplicand_i;
            r_acc    <= '0;
            r_q      <= w_mplier_ext;
            r_q_1    <= 1'b0;
            r_count  <= '0;
            if (w_bypass) begin
              r_product <= '0;
              r_state   <= DONE;
            end else begin
              r_state   <= CALC;
            end
          end
        end
        CALC: begin
          r_acc   <= w_acc_nxt;
          r_q     <= w_q_nxt;
          r_q_1   <= r_q[1];
          r_count <= r_count + 1'b1;
          // Product is captured on the last step so it is already valid
          // during the DONE cycle that carries data_valid_o.
          if (r_count == CW'(ITER - 1)) begin
            r_product <= w_prod_nxt;
            r_state   <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready_o      = (r_state == IDLE);
  assign data_valid_o = (r_state == DONE);
  assign product_o    = r_product;

endmodule

// File: tb/tb_booth_multiply_radix4_fsmd.sv
module tb_booth_multiply_radix4_fsmd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start8 = 1'b0, sgn8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        rdy8, vld8;
  logic [15:0] p8;

  logic        start16 = 1'b0, sgn16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        rdy16, vld16;
  logic [31:0] p16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_multiply_radix4_fsmd #(.WIDTH(8)) dut8 (
    .clk_i          (clk),
    .reset_i        (rst),
    .start_i        (start8),
    .signed_i       (sgn8),
    .multiplicand_i (a8),
    .multiplier_i   (b8),
    .ready_o        (rdy8),
    .data_valid_o   (vld8),
    .product_o      (p8)
  );

  booth_multiply_radix4_fsmd #(.WIDTH(16)) dut16 (
    .clk_i          (clk),
    .reset_i        (rst),
    .start_i        (start16),
    .signed_i       (sgn16),
    .multiplicand_i (a16),
    .multiplier_i   (b16),
    .ready_o        (rdy16),
    .data_valid_o   (vld16),
    .product_o      (p16)
  );

  // Reference: plain integer multiply of the interpreted operands.
  function automatic logic [31:0] model(input bit wide, input bit sgn,
                                        input logic [15:0] a, input logic [15:0] b);
    longint x, y;
    logic [63:0] p;
    if (wide) begin
      x = sgn ? longint'($signed(a)) : longint'(a);
      y = sgn ? longint'($signed(b)) : longint'(b);
    end else begin
      x = sgn ? longint'($signed(a[7:0])) : longint'(a[7:0]);
      y = sgn ? longint'($signed(b[7:0])) : longint'(b[7:0]);
    end
    p = 64'(x * y);
    return wide ? p[31:0] : {16'h0000, p[15:0]};
  endfunction

  function automatic logic obs_rdy(input bit wide);
    return wide ? rdy16 : rdy8;
  endfunction

  function automatic logic obs_vld(input bit wide);
    return wide ? vld16 : vld8;
  endfunction

  function automatic logic [31:0] obs_p(input bit wide);
    return wide ? p16 : {16'h0000, p8};
  endfunction

  task automatic drive(input bit wide, input bit st, input bit sg,
                       input logic [15:0] a, input logic [15:0] b);
    if (wide) begin
      start16 = st; sgn16 = sg; a16 = a; b16 = b;
    end else begin
      start8 = st; sgn8 = sg; a8 = a[7:0]; b8 = b[7:0];
    end
  endtask

  // One full operation: accept, then watch cycles 1..exp+2 relative to the accept edge.
  task automatic do_op(input bit wide, input bit sgn, input logic [15:0] a,
                       input logic [15:0] b, input logic [31:0] exp_p, input string nm);
    int w, it, exp_c, first_c, n_vld, lim;
    bit byp, rdy_after;
    logic [31:0] got_p;
    w = wide ? 16 : 8;
    it = (w + 2) / 2;
    byp = 1'b0;
`ifdef BOOTH_ZERO_BYPASS_EN
    byp = wide ? (a == 16'h0 || b == 16'h0) : (a[7:0] == 8'h0 || b[7:0] == 8'h0);
`endif
    exp_c = byp ? 1 : it + 1;
    lim = exp_c + 2;
    first_c = -1; n_vld = 0; rdy_after = 1'b0; got_p = '0;
    @(negedge clk);
    checks++;
    if (obs_rdy(wide) !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before_accept: got %b want 1", nm, obs_rdy(wide));
    end
    drive(wide, 1'b1, sgn, a, b);
    @(posedge clk);
    for (int c = 1; c <= lim; c++) begin
      @(negedge clk);
      if (c == 1) drive(wide, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
      if (obs_vld(wide) === 1'b1) begin
        n_vld++;
        if (first_c < 0) begin
          first_c = c;
          got_p = obs_p(wide);
        end
      end
      if (c == exp_c + 1) rdy_after = (obs_rdy(wide) === 1'b1);
    end
    checks++;
    if (first_c != exp_c) begin
      errors++;
      $display("FAIL %s valid_cycle a=%h b=%h: got %0d want %0d", nm, a, b, first_c, exp_c);
    end
    checks++;
    if (n_vld != 1) begin
      errors++;
      $display("FAIL %s valid_width: got %0d cycles want 1", nm, n_vld);
    end
    checks++;
    if (got_p !== exp_p) begin
      errors++;
      $display("FAIL %s product s=%0d a=%h b=%h: got %h want %h", nm, sgn, a, b, got_p, exp_p);
    end
    checks++;
    if (!rdy_after) begin
      errors++;
      $display("FAIL %s ready_after_done: got 0 want 1", nm);
    end
    checks++;
    if (obs_p(wide) !== exp_p) begin
      errors++;
      $display("FAIL %s product_held: got %h want %h", nm, obs_p(wide), exp_p);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rdy8 !== 1'b1 || rdy16 !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b/%b want 1/1", rdy8, rdy16);
    end
    checks++;
    if (vld8 !== 1'b0 || vld16 !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b/%b want 0/0", vld8, vld16);
    end
    checks++;
    if (p8 !== 16'h0 || p16 !== 32'h0) begin
      errors++;
      $display("FAIL reset_product: got %h/%h want 0/0", p8, p16);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    do_op(1'b0, 1'b1, 16'h79, 16'h9D, 32'h0000D135, "s8_79x9D");
    do_op(1'b0, 1'b0, 16'h79, 16'h9D, 32'h00004A35, "u8_79x9D");
    do_op(1'b0, 1'b0, 16'hFF, 16'hFF, 32'h0000FE01, "u8_FFxFF");
    do_op(1'b0, 1'b1, 16'h80, 16'h80, 32'h00004000, "s8_80x80");
    do_op(1'b0, 1'b1, 16'h80, 16'h7F, 32'h0000C080, "s8_80x7F");
    do_op(1'b0, 1'b1, 16'hFF, 16'h01, 32'h0000FFFF, "s8_FFx01");
    do_op(1'b0, 1'b0, 16'h00, 16'h5A, 32'h00000000, "zero_00x5A");
    do_op(1'b1, 1'b1, 16'h8000, 16'h8000, 32'h40000000, "s16_min_sq");
    do_op(1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "u16_full");
  endtask

  task automatic test_back_to_back();
    int it, v1, v2, nv;
    logic [15:0] pr1, pr2;
    bit rdy_gap;
    it = 5; v1 = -1; v2 = -1; nv = 0; pr1 = '0; pr2 = '0; rdy_gap = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 16'h79, 16'h9D);
    @(posedge clk);
    for (int c = 1; c <= 2 * it + 4; c++) begin
      @(negedge clk);
      if (c == 1) drive(1'b0, 1'b1, 1'b0, 16'h12, 16'h34);
      if (vld8 === 1'b1) begin
        nv++;
        if (v1 < 0) begin v1 = c; pr1 = p8; end
        else if (v2 < 0) begin v2 = c; pr2 = p8; end
      end
      if (c == it + 2) rdy_gap = (rdy8 === 1'b1);
      if (c == it + 3) drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    end
    checks++;
    if (v1 != it + 1 || pr1 !== 16'hD135) begin
      errors++;
      $display("FAIL b2b_first: got cycle %0d product %h want cycle %0d product d135", v1, pr1, it + 1);
    end
    checks++;
    if (!rdy_gap) begin
      errors++;
      $display("FAIL b2b_idle_gap: ready got 0 want 1");
    end
    checks++;
    if (v2 != 2 * it + 3 || pr2 !== 16'h03A8) begin
      errors++;
      $display("FAIL b2b_second: got cycle %0d product %h want cycle %0d product 03a8", v2, pr2, 2 * it + 3);
    end
    checks++;
    if (nv != 2) begin
      errors++;
      $display("FAIL b2b_valid_count: got %0d want 2", nv);
    end
  endtask

  task automatic test_reset_mid_calc();
    int nv;
    bit rdy_low;
    nv = 0; rdy_low = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 16'h79, 16'h9D);
    @(posedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    end
    // Reset and a competing start in the same cycle: reset must win.
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 16'h11, 16'h22);
    @(negedge clk);
    checks++;
    if (rdy8 !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_ready: got %b want 1", rdy8);
    end
    checks++;
    if (vld8 !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_valid: got %b want 0", vld8);
    end
    checks++;
    if (p8 !== 16'h0) begin
      errors++;
      $display("FAIL rst_mid_product: got %h want 0000", p8);
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (vld8 === 1'b1) nv++;
      if (rdy8 !== 1'b1) rdy_low = 1'b1;
    end
    checks++;
    if (nv != 0 || rdy_low) begin
      errors++;
      $display("FAIL rst_mid_quiet: got %0d valid pulses, ready_dropped=%b want 0/0", nv, rdy_low);
    end
    do_op(1'b0, 1'b0, 16'h03, 16'h05, 32'h0000000F, "after_reset_3x5");
  endtask

  task automatic test_random16();
    bit sg;
    logic [15:0] a, b;
    for (int n = 0; n < 1000; n++) begin
      sg = 1'($urandom_range(0, 1));
      a = 16'($urandom);
      b = 16'($urandom);
      do_op(1'b1, sg, a, b, model(1'b1, sg, a, b), "rand16");
    end
  endtask

  task automatic test_random8();
    bit sg;
    logic [15:0] a, b;
    for (int n = 0; n < 100; n++) begin
      sg = 1'($urandom_range(0, 1));
      a = {8'h00, 8'($urandom)};
      b = {8'h00, 8'($urandom)};
      do_op(1'b0, sg, a, b, model(1'b0, sg, a, b), "rand8");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_calc();
    test_random8();
    test_random16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
